// File: rtl/threshold_detector_multi_pkg.sv
// Shared definitions for the multi-mode threshold detector: FSM state encoding
// and the layout of the offset-table configuration word.
package threshold_detector_multi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ARMING = 2'd1,
    ST_ACTIVE = 2'd2
  } state_t;

  // Config word is {strict, signed offset[DW:0]}
  localparam int CFG_OFF_LSB = 0;

  function automatic int cfg_width(input int dw);
    return dw + 2;
  endfunction

  function automatic int cfg_strict_bit(input int dw);
    return dw + 1;
  endfunction

endpackage

// File: rtl/threshold_detector_multi_offset_table.sv
// Per-mode offset/strict register file: synchronous write, combinational read,
// so a write and a read of the same entry in one cycle returns the old value.
module threshold_offset_table
  import threshold_detector_multi_pkg::*;
#(
  parameter int DW = 10,
  parameter int MW = 2
) (
  input  logic                      iCLK,
  input  logic                      iRST,
  input  logic                      iWE,
  input  logic [MW-1:0]             iWADDR,
  input  logic [cfg_width(DW)-1:0]  iWDATA,
  input  logic [MW-1:0]             iRADDR,
  output logic [cfg_width(DW)-1:0]  oRDATA
);

  localparam int DEPTH = 2**MW;

  logic [cfg_width(DW)-1:0] r_entry [DEPTH];

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_entry[i] <= '0;
      end
    end else if (iWE) begin
      r_entry[iWADDR] <= iWDATA;
    end
  end

  assign oRDATA = r_entry[iRADDR];

endmodule

// File: rtl/threshold_detector_multi.sv
// CFAR-style detector on the STFT magnitude stream: per-mode offset, strict/
// non-strict compare, hysteresis release, N-hit persistence, per-frame count.
module threshold_detector_multi
  import threshold_detector_multi_pkg::*;
#(
  parameter int DW      = 10,
  parameter int MW      = 2,
  parameter int PERSIST = 3,
  parameter int CW      = 8
) (
  input  logic                     iCLK,
  input  logic                     iRST,
  input  logic                     iEN,
  input  logic [DW-1:0]            iDATA,
  input  logic [MW-1:0]            iMODE,
  input  logic [DW-1:0]            iTH,
  input  logic [DW-2:0]            iHYST,
  input  logic                     iSOF,
  input  logic                     iEOF,
  input  logic                     iCFG_WE,
  input  logic [MW-1:0]            iCFG_ADDR,
  input  logic [cfg_width(DW)-1:0] iCFG_DATA,
  output logic                     oDATA,
  output logic                     oEN,
  output logic [CW-1:0]            oCNT,
  output logic                     oCNT_VLD
);

  localparam int SW         = DW + 3;
  localparam int RW         = $clog2(PERSIST + 1);
  localparam int STRICT_BIT = cfg_strict_bit(DW);
  localparam logic [RW-1:0] RUN_LAST = RW'(PERSIST - 1);
  localparam logic [CW-1:0] CNT_MAX  = '1;

  // ---------------- stage 1: offset lookup and score ----------------
  logic [cfg_width(DW)-1:0] w_cfg_word;
  logic [DW:0]              w_off;
  logic signed [SW-1:0]     w_data_x;
  logic signed [SW-1:0]     w_off_x;
  logic signed [SW-1:0]     w_score;

  threshold_offset_table #(
    .DW (DW),
    .MW (MW)
  ) u_offset_table (
    .iCLK   (iCLK),
    .iRST   (iRST),
    .iWE    (iCFG_WE),
    .iWADDR (iCFG_ADDR),
    .iWDATA (iCFG_DATA),
    .iRADDR (iMODE),
    .oRDATA (w_cfg_word)
  );

  assign w_off    = w_cfg_word[CFG_OFF_LSB +: DW+1];
  assign w_data_x = {2'b00, iDATA, 1'b0};
  assign w_off_x  = {{2{w_off[DW]}}, w_off};
  assign w_score  = w_data_x - w_off_x;

  logic                 r_s1_vld;
  logic signed [SW-1:0] r_s1_score;
  logic                 r_s1_strict;
  logic                 r_s1_sof;
  logic                 r_s1_eof;

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      r_s1_vld    <= 1'b0;
      r_s1_score  <= '0;
      r_s1_strict <= 1'b0;
      r_s1_sof    <= 1'b0;
      r_s1_eof    <= 1'b0;
    end else begin
      r_s1_vld <= iEN;
      if (iEN) begin
        r_s1_score  <= w_score;
        r_s1_strict <= w_cfg_word[STRICT_BIT];
        r_s1_sof    <= iSOF;
        r_s1_eof    <= iEOF;
      end
    end
  end

  // ---------------- stage 2: compare, FSM, frame count ----------------
  logic signed [SW-1:0] w_th_x;
  logic signed [SW-1:0] w_hyst_x;
  logic signed [SW-1:0] w_rel_th;
  logic                 w_hit;
  logic                 w_rel;

  assign w_th_x   = {{3{iTH[DW-1]}}, iTH};
  assign w_hyst_x = {4'b0000, iHYST};
  assign w_rel_th = w_th_x - w_hyst_x;
  assign w_hit    = r_s1_strict ? (r_s1_score > w_th_x) : (r_s1_score >= w_th_x);
  assign w_rel    = r_s1_score < w_rel_th;

  state_t        r_state;
  logic [RW-1:0] r_run;
  logic [CW-1:0] r_cnt;
  state_t        w_state_cur;
  state_t        w_state_next;
  logic [RW-1:0] w_run_cur;
  logic [RW-1:0] w_run_next;
  logic [CW-1:0] w_cnt_cur;
  logic [CW-1:0] w_cnt_inc;
  logic [CW-1:0] w_cnt_next;
  logic          w_enter;
  logic          w_odata;

  // SOF wipes the frame context before the sample itself is evaluated
  assign w_state_cur = r_s1_sof ? ST_IDLE : r_state;
  assign w_run_cur   = r_s1_sof ? '0 : r_run;
  assign w_cnt_cur   = r_s1_sof ? '0 : r_cnt;

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      r_state <= ST_IDLE;
      r_run   <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_run   <= w_run_next;
      r_cnt   <= w_cnt_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_run_next   = r_run;
    w_enter      = 1'b0;
    if (r_s1_vld) begin
      w_state_next = w_state_cur;
      w_run_next   = w_run_cur;
      unique case (w_state_cur)
        ST_IDLE: begin
          if (w_hit) begin
            if (PERSIST == 1) begin
              w_state_next = ST_ACTIVE;
              w_run_next   = '0;
              w_enter      = 1'b1;
            end else begin
              w_state_next = ST_ARMING;
              w_run_next   = RW'(1);
            end
          end
        end
        ST_ARMING: begin
          if (!w_hit) begin
            w_state_next = ST_IDLE;
            w_run_next   = '0;
          end else if (w_run_cur == RUN_LAST) begin
            w_state_next = ST_ACTIVE;
            w_run_next   = '0;
            w_enter      = 1'b1;
          end else begin
            w_run_next = w_run_cur + 1'b1;
          end
        end
        ST_ACTIVE: begin
          if (w_rel) begin
            w_state_next = ST_IDLE;
            w_run_next   = '0;
          end
        end
        default: begin
          w_state_next = ST_IDLE;
          w_run_next   = '0;
        end
      endcase
    end
  end

  always_comb begin
    w_odata    = (w_state_next == ST_ACTIVE);
    w_cnt_inc  = (w_enter && (w_cnt_cur != CNT_MAX)) ? w_cnt_cur + 1'b1 : w_cnt_cur;
    w_cnt_next = r_cnt;
    if (r_s1_vld) begin
      w_cnt_next = r_s1_eof ? '0 : w_cnt_inc;
    end
  end

  logic          r_oen;
  logic          r_odata;
  logic [CW-1:0] r_ocnt;
  logic          r_ocnt_vld;

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      r_oen      <= 1'b0;
      r_odata    <= 1'b0;
      r_ocnt     <= '0;
      r_ocnt_vld <= 1'b0;
    end else begin
      r_oen      <= r_s1_vld;
      r_odata    <= r_s1_vld & w_odata;
      r_ocnt_vld <= r_s1_vld & r_s1_eof;
      if (r_s1_vld && r_s1_eof) begin
        r_ocnt <= w_cnt_inc;
      end
    end
  end

  assign oEN      = r_oen;
  assign oDATA    = r_odata;
  assign oCNT     = r_ocnt;
  assign oCNT_VLD = r_ocnt_vld;

endmodule

// File: tb/tb_threshold_detector_multi.sv
// Directed plus randomised bench for threshold_detector_multi; a second
// instance with a 2-bit counter exercises count saturation on the same stream.
module tb_threshold_detector_multi;

  localparam int PERSIST = 3;

  logic        clk = 1'b0;
  logic        rst, en, sof, eof, cfg_we;
  logic [9:0]  data, th;
  logic [1:0]  mode, cfg_addr;
  logic [8:0]  hyst;
  logic [11:0] cfg_data;

  logic       o_data, o_en, o_cnt_vld;
  logic [7:0] o_cnt;
  logic       o2_data, o2_en, o2_cnt_vld;
  logic [1:0] o2_cnt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  threshold_detector_multi dut (
    .iCLK(clk), .iRST(rst), .iEN(en), .iDATA(data), .iMODE(mode), .iTH(th),
    .iHYST(hyst), .iSOF(sof), .iEOF(eof), .iCFG_WE(cfg_we), .iCFG_ADDR(cfg_addr),
    .iCFG_DATA(cfg_data), .oDATA(o_data), .oEN(o_en), .oCNT(o_cnt), .oCNT_VLD(o_cnt_vld)
  );

  threshold_detector_multi #(.CW(2)) dut_c2 (
    .iCLK(clk), .iRST(rst), .iEN(en), .iDATA(data), .iMODE(mode), .iTH(th),
    .iHYST(hyst), .iSOF(sof), .iEOF(eof), .iCFG_WE(cfg_we), .iCFG_ADDR(cfg_addr),
    .iCFG_DATA(cfg_data), .oDATA(o2_data), .oEN(o2_en), .oCNT(o2_cnt), .oCNT_VLD(o2_cnt_vld)
  );

  // Reference model: consecutive-hit count, active flag, saturating frame counts
  typedef struct {
    bit en;
    bit d;
    bit cv;
    int cnt;
    int cnt2;
  } exp_t;

  exp_t p1, p2;
  int   m_run, m_cnt, m_cnt2, m_hold, m_hold2;
  bit   m_act;
  int   tab_off [4];
  bit   tab_str [4];

  task automatic model_step();
    exp_t e;
    int   score, th_i, hy_i;
    bit   hit, rel;
    if (rst) begin
      m_run = 0; m_cnt = 0; m_cnt2 = 0; m_hold = 0; m_hold2 = 0; m_act = 0;
      for (int i = 0; i < 4; i++) begin
        tab_off[i] = 0;
        tab_str[i] = 0;
      end
      p1 = '{default: 0};
      p2 = '{default: 0};
      return;
    end
    p2 = p1;
    e  = '{default: 0};
    if (en) begin
      if (sof) begin
        m_act = 0; m_run = 0; m_cnt = 0; m_cnt2 = 0;
      end
      score = 2 * int'(data) - tab_off[mode];
      th_i  = int'($signed(th));
      hy_i  = int'(hyst);
      hit   = tab_str[mode] ? (score > th_i) : (score >= th_i);
      rel   = score < (th_i - hy_i);
      if (m_act) begin
        if (rel) m_act = 0;
      end else if (hit) begin
        m_run++;
        if (m_run >= PERSIST) begin
          m_act  = 1;
          m_run  = 0;
          m_cnt  = (m_cnt < 255) ? m_cnt + 1 : 255;
          m_cnt2 = (m_cnt2 < 3) ? m_cnt2 + 1 : 3;
        end
      end else begin
        m_run = 0;
      end
      e.en = 1;
      e.d  = m_act;
      if (eof) begin
        e.cv    = 1;
        m_hold  = m_cnt;
        m_hold2 = m_cnt2;
        m_cnt   = 0;
        m_cnt2  = 0;
      end
    end
    e.cnt  = m_hold;
    e.cnt2 = m_hold2;
    p1 = e;
    if (cfg_we) begin
      tab_off[cfg_addr] = int'($signed(cfg_data[10:0]));
      tab_str[cfg_addr] = cfg_data[11];
    end
  endtask

  task automatic check_val(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_val("oEN", int'(o_en), int'(p2.en));
    check_val("oDATA", int'(o_data), int'(p2.d));
    check_val("oCNT_VLD", int'(o_cnt_vld), int'(p2.cv));
    check_val("oCNT", int'(o_cnt), p2.cnt);
    check_val("oCNT_VLD_cw2", int'(o2_cnt_vld), int'(p2.cv));
    check_val("oCNT_cw2", int'(o2_cnt), p2.cnt2);
    $display("t=%0t en=%0b d=%0d m=%0d sof=%0b eof=%0b | oEN=%0b oDATA=%0b oCNT=%0d vld=%0b",
             $time, en, data, mode, sof, eof, o_en, o_data, o_cnt, o_cnt_vld);
  endtask

  task automatic send(input logic [9:0] d, input logic [1:0] m, input logic s, input logic e);
    en = 1'b1; data = d; mode = m; sof = s; eof = e;
    tick();
    en = 1'b0; sof = 1'b0; eof = 1'b0; cfg_we = 1'b0;
  endtask

  task automatic idle(input int n);
    en = 1'b0; sof = 1'b0; eof = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic cfg(input logic [1:0] a, input logic [11:0] w);
    cfg_we = 1'b1; cfg_addr = a; cfg_data = w;
    tick();
    cfg_we = 1'b0;
  endtask

  initial begin
    int n, off;
    bit lvl;
    logic [11:0] w;
    rst = 1'b1; en = 1'b0; sof = 1'b0; eof = 1'b0; cfg_we = 1'b0;
    data = '0; mode = '0; th = '0; hyst = '0; cfg_addr = '0; cfg_data = '0;
    p1 = '{default: 0};
    p2 = '{default: 0};
    tick(); tick();
    rst = 1'b0;
    idle(2);

    // 1: score 1 vs TH 0, persistence of three
    cfg(2'd0, {1'b0, 11'd9});
    th = 10'd0; hyst = 9'd0;
    repeat (4) send(10'd5, 2'd0, 1'b0, 1'b0);
    idle(3);

    // 2: hysteresis, TH=20 HYST=6
    th = 10'd20; hyst = 9'd6;
    idle(2);
    send(10'd10, 2'd3, 1'b1, 1'b0);
    send(10'd10, 2'd3, 1'b0, 1'b0);
    send(10'd10, 2'd3, 1'b0, 1'b0);
    send(10'd8,  2'd3, 1'b0, 1'b0);
    send(10'd6,  2'd3, 1'b0, 1'b1);
    idle(3);

    // 3: strict compare at score == TH, then non-strict
    cfg(2'd2, {1'b1, 11'd0});
    send(10'd10, 2'd2, 1'b1, 1'b0);
    repeat (3) send(10'd10, 2'd2, 1'b0, 1'b0);
    send(10'd0, 2'd2, 1'b0, 1'b1);
    cfg(2'd2, {1'b0, 11'd0});
    send(10'd10, 2'd2, 1'b1, 1'b0);
    repeat (3) send(10'd10, 2'd2, 1'b0, 1'b0);
    send(10'd0, 2'd2, 1'b0, 1'b1);
    idle(3);

    // 4: full-range score, no wrap
    th = 10'd511;
    cfg(2'd1, {1'b0, 11'h600});
    cfg(2'd2, {1'b0, 11'd1008});
    idle(2);
    send(10'd1023, 2'd1, 1'b1, 1'b0);
    repeat (2) send(10'd1023, 2'd1, 1'b0, 1'b0);
    repeat (2) send(10'd0, 2'd2, 1'b0, 1'b0);
    send(10'd0, 2'd2, 1'b0, 1'b1);
    idle(3);

    // 5: five bursts in one frame (saturates the 2-bit counter), single-sample frame
    th = 10'd20; hyst = 9'd6;
    idle(2);
    send(10'd0, 2'd3, 1'b1, 1'b0);
    for (int b = 0; b < 5; b++) begin
      repeat (3) send(10'd10, 2'd3, 1'b0, 1'b0);
      send(10'd0, 2'd3, 1'b0, 1'b0);
      if (b == 2) idle(2);
    end
    send(10'd0, 2'd3, 1'b0, 1'b1);
    send(10'd10, 2'd3, 1'b1, 1'b1);
    idle(3);

    // 6: reset while active, re-arm, write coinciding with an accept
    send(10'd10, 2'd3, 1'b1, 1'b0);
    repeat (3) send(10'd10, 2'd3, 1'b0, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    send(10'd10, 2'd3, 1'b1, 1'b0);
    repeat (2) send(10'd10, 2'd3, 1'b0, 1'b0);
    cfg_we = 1'b1; cfg_addr = 2'd3; cfg_data = {1'b0, 11'd20};
    send(10'd10, 2'd3, 1'b0, 1'b0);
    send(10'd10, 2'd3, 1'b0, 1'b1);
    idle(3);

    // Randomised frames
    for (int f = 0; f < 60; f++) begin
      th   = 10'($urandom_range(200, 511));
      hyst = 9'($urandom_range(0, 300));
      for (int a = 0; a < 4; a++) begin
        off = int'($urandom_range(0, 400)) - 200;
        w   = {($urandom_range(0, 3) == 0), off[10:0]};
        cfg(2'(a), w);
      end
      idle(2);
      n   = int'($urandom_range(4, 40));
      lvl = 1'b0;
      for (int s = 0; s < n; s++) begin
        if ($urandom_range(0, 4) == 0) lvl = ~lvl;
        if ($urandom_range(0, 5) == 0) idle(int'($urandom_range(1, 3)));
        if ($urandom_range(0, 150) == 0) begin
          rst = 1'b1;
          tick();
          rst = 1'b0;
        end
        if ($urandom_range(0, 30) == 0) begin
          off = int'($urandom_range(0, 400)) - 200;
          cfg_we   = 1'b1;
          cfg_addr = 2'($urandom_range(0, 3));
          cfg_data = {($urandom_range(0, 3) == 0), off[10:0]};
        end
        send(lvl ? 10'($urandom_range(250, 1023)) : 10'($urandom_range(0, 200)),
             2'($urandom_range(0, 3)), (s == 0), (s == n - 1));
      end
      idle(3);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
